// File: rtl/led_control_axil_slave.sv
// AXI4-Lite register file (CTRL, LED_VAL, BLINK_DIV, SCRATCH) driving board LEDs with an optional blinker.
// Write response 1 cycle after AW+W commit, read data 1 cycle after AR; B/R held until BREADY/RREADY.
module led_control_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            LEDS
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_LED_VAL   = 2'd1;
  localparam logic [1:0] REG_BLINK_DIV = 2'd2;

  logic                 in_rdy_q, in_rdy_d;
  logic                 aw_held_q, aw_held_d;
  logic [1:0]           aw_idx_q, aw_idx_d;
  logic                 w_held_q, w_held_d;
  logic [DW-1:0]        w_data_q, w_data_d;
  logic [SW-1:0]        w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;
  logic                 rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [3:0][DW-1:0]   regs_q, regs_d;
  logic [DW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;

  logic                 awready, wready, arready;
  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [1:0]           wr_idx, rd_idx;
  logic [DW-1:0]        wr_data;
  logic [SW-1:0]        wr_strb;
  logic                 led_en, blink_en, blink_on;
  logic [DW-1:0]        blink_div;
  logic [LED_WIDTH-1:0] led_val;
  logic                 unused_sigs;

  assign unused_sigs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Ready gating: nothing is accepted until the first edge after reset release.
  assign awready = in_rdy_q & ~aw_held_q & ~bvalid_q;
  assign wready  = in_rdy_q & ~w_held_q & ~bvalid_q;
  assign arready = in_rdy_q & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & awready;
  assign w_hs  = S_AXI_WVALID & wready;
  assign ar_hs = S_AXI_ARVALID & arready;

  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
  assign rd_idx  = S_AXI_ARADDR[3:2];

  assign led_en    = regs_q[REG_CTRL][0];
  assign blink_en  = regs_q[REG_CTRL][1];
  assign blink_on  = led_en & blink_en;
  assign blink_div = regs_q[REG_BLINK_DIV];
  assign led_val   = regs_q[REG_LED_VAL][LED_WIDTH-1:0];

  always_comb begin
    in_rdy_d  = 1'b1;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) begin
          regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Read samples the pre-edge register value, so a same-edge write is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[rd_idx];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Using >= lets a shrinking BLINK_DIV wrap immediately instead of running to 2^32.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_on) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q >= blink_div) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    leds_d = '0;
    if (led_en) begin
      if (!blink_en || phase_q) begin
        leds_d = led_val;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      in_rdy_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_held_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      regs_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      leds_q      <= '0;
    end else begin
      in_rdy_q    <= in_rdy_d;
      aw_held_q   <= aw_held_d;
      aw_idx_q    <= aw_idx_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      regs_q      <= regs_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      leds_q      <= leds_d;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign LEDS          = leds_q;

endmodule

// File: tb/tb_led_control_axil_slave.sv
// Directed bench for led_control_axil_slave; B/R responses are checked by a queue-based scoreboard.
module tb_led_control_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic [7:0]  LEDS;

  int checks = 0;
  int failures = 0;
  int b_count = 0;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];

  always #5 ACLK = ~ACLK;

  led_control_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .LED_WIDTH(8)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LEDS(LEDS)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        b_count++;
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected actual=bresp 0x%0h expected=no response", S_AXI_BRESP);
        end else begin
          chk("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_b.pop_front()});
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (exp_r.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected actual=rdata 0x%0h expected=no response", S_AXI_RDATA);
        end else begin
          chk("rdata", S_AXI_RDATA, exp_r.pop_front());
          chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic hs_loop();
    int cyc = 0;
    logic aw_now, w_now;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && cyc < 100) begin
      @(negedge ACLK);
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_now) S_AXI_AWVALID = 1'b0;
      if (w_now)  S_AXI_WVALID  = 1'b0;
      cyc++;
    end
    if (cyc >= 100) begin
      checks++; failures++;
      $display("FAIL write_timeout actual=no handshake expected=AW/W accepted");
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d;  S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    hs_loop();
    exp_b.push_back(2'b00);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
    int cyc = 0;
    logic hs = 1'b0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    exp_r.push_back(exp);
    while (!hs && cyc < 100) begin
      @(negedge ACLK);
      hs = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!hs) begin
      checks++; failures++;
      $display("FAIL read_timeout actual=no handshake expected=AR accepted");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge ACLK);
    while ((S_AXI_BVALID || S_AXI_RVALID) && n < 100) begin
      n++;
      @(negedge ACLK);
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=response pending expected=idle");
    end
    @(posedge ACLK); #1;
  endtask

  task automatic run_len(input logic [7:0] v, output int n);
    n = 0;
    while (LEDS == v && n < 50) begin
      n++;
      @(negedge ACLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n, t;
    // Reset
    #3 ARESETN = 1'b0;
    repeat (20) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    chk("rst_wready",  {31'd0, S_AXI_WREADY},  32'd0);
    chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
    chk("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
    chk("rst_rdata",   S_AXI_RDATA, 32'd0);
    chk("rst_leds",    {24'd0, LEDS}, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("post_rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    chk("post_rst_wready",  {31'd0, S_AXI_WREADY},  32'd1);
    chk("post_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

    // Sequential write then readback
    do_write(4'h0, 32'h1, 4'hF);
    do_write(4'h4, 32'h2, 4'hF);
    do_write(4'h8, 32'h3, 4'hF);
    do_write(4'hC, 32'h4, 4'hF);
    wait_idle();
    do_read(4'h0, 32'h1);
    do_read(4'h4, 32'h2);
    do_read(4'h8, 32'h3);
    do_read(4'hC, 32'h4);
    wait_idle();
    @(negedge ACLK);
    chk("leds_static", {24'd0, LEDS}, 32'h02);
    @(posedge ACLK); #1;

    // W three cycles ahead of AW
    b0 = b_count;
    S_AXI_WDATA = 32'h5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    chk("w_first_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      chk("w_held_wready", {31'd0, S_AXI_WREADY}, 32'd0);
      chk("w_held_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    chk("late_aw_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    exp_b.push_back(2'b00);
    @(negedge ACLK);
    chk("late_aw_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    @(posedge ACLK); #1;
    wait_idle();
    chk("late_aw_bcount", b_count - b0, 32'd1);
    do_read(4'h4, 32'h5A);
    wait_idle();

    // Byte strobes
    do_write(4'hC, 32'h00000004, 4'hF);
    do_write(4'hC, 32'hAABBCCDD, 4'b0010);
    wait_idle();
    do_read(4'hC, 32'h0000CC04);
    wait_idle();

    // B backpressure
    b0 = b_count;
    S_AXI_BREADY = 1'b0;
    do_write(4'h8, 32'h10, 4'hF);
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    repeat (5) begin
      @(negedge ACLK);
      chk("bp_bvalid",  {31'd0, S_AXI_BVALID},  32'd1);
      chk("bp_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      chk("bp_wready",  {31'd0, S_AXI_WREADY},  32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    hs_loop();
    exp_b.push_back(2'b00);
    wait_idle();
    chk("bp_bcount", b_count - b0, 32'd2);
    do_read(4'h8, 32'h10);
    do_read(4'hC, 32'h77);
    wait_idle();

    // Blink generator
    do_write(4'h0, 32'h0, 4'hF);
    do_write(4'h4, 32'hA5, 4'hF);
    do_write(4'h8, 32'h4, 4'hF);
    wait_idle();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("leds_disabled", {24'd0, LEDS}, 32'h0);
    @(posedge ACLK); #1;
    do_write(4'h0, 32'h3, 4'hF);
    t = 0;
    @(negedge ACLK);
    while (LEDS != 8'hA5 && t < 30) begin
      t++;
      @(negedge ACLK);
    end
    chk("blink_start", {24'd0, LEDS}, 32'hA5);
    run_len(8'hA5, n); chk("blink_on_len1",  n, 32'd5);
    run_len(8'h00, n); chk("blink_off_len1", n, 32'd5);
    run_len(8'hA5, n); chk("blink_on_len2",  n, 32'd5);
    run_len(8'h00, n); chk("blink_off_len2", n, 32'd5);
    @(posedge ACLK); #1;
    do_write(4'h0, 32'h1, 4'hF);
    wait_idle();
    repeat (3) @(posedge ACLK);
    repeat (12) begin
      @(negedge ACLK);
      chk("steady_leds", {24'd0, LEDS}, 32'hA5);
    end

    repeat (5) @(posedge ACLK);
    chk("b_queue_empty", exp_b.size(), 32'd0);
    chk("r_queue_empty", exp_r.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
